// File: rtl/i2s_pkg.sv
// Shared constants and types for the Philips-format I2S transmitter.
package i2s_pkg;

  localparam int FRAME_BITS = 64;
  localparam int SLOT_BITS  = 32;
  localparam int BIT_CNT_W  = $clog2(FRAME_BITS);
  localparam int SLOT_IDX_W = $clog2(SLOT_BITS);

  typedef logic signed [15:0] sample_t;

  typedef enum logic {
    SLOT_L = 1'b0,
    SLOT_R = 1'b1
  } i2s_slot_e;

  // Bits 0..31 of a frame belong to the left slot, 32..63 to the right slot.
  function automatic i2s_slot_e slot_of(input logic [BIT_CNT_W-1:0] bit_idx);
    return (bit_idx >= BIT_CNT_W'(SLOT_BITS)) ? SLOT_R : SLOT_L;
  endfunction

endpackage

// File: rtl/i2s_clkgen.sv
// Bit-clock divider and frame bit counter; produces BCLK, LRCLK and the
// falling-edge / frame-load strobes that pace the transmitter datapath.
module i2s_clkgen
  import i2s_pkg::*;
#(
  parameter int CLK_DIV_HALF = 32
) (
  input  logic                 audio_clk,
  input  logic                 rst_in,
  output logic                 i2s_bclk,
  output logic                 i2s_lrclk,
  output logic [BIT_CNT_W-1:0] next_bit_cnt,
  output logic                 fall_evt,
  output logic                 load_evt
);

  localparam int DIV_W = (CLK_DIV_HALF > 1) ? $clog2(CLK_DIV_HALF) : 1;

  logic [DIV_W-1:0]     div_cnt;
  logic [BIT_CNT_W-1:0] bit_cnt;
  logic                 div_tc;

  assign div_tc       = (div_cnt == DIV_W'(CLK_DIV_HALF - 1));
  assign fall_evt     = div_tc && i2s_bclk;
  assign next_bit_cnt = bit_cnt + BIT_CNT_W'(1);
  assign load_evt     = fall_evt && (next_bit_cnt == '0);

  // bit_cnt resets to the last frame bit so the very first BCLK fall loads a frame.
  always_ff @(posedge audio_clk or negedge rst_in) begin
    if (!rst_in) begin
      div_cnt   <= '0;
      i2s_bclk  <= 1'b0;
      bit_cnt   <= BIT_CNT_W'(FRAME_BITS - 1);
      i2s_lrclk <= 1'b1;
    end else begin
      div_cnt <= div_tc ? '0 : div_cnt + DIV_W'(1);
      if (div_tc) begin
        i2s_bclk <= ~i2s_bclk;
      end
      if (fall_evt) begin
        bit_cnt   <= next_bit_cnt;
        i2s_lrclk <= (slot_of(next_bit_cnt) == SLOT_R);
      end
    end
  end

endmodule

// File: rtl/i2s_tx.sv
// I2S transmitter top: holding register, handshake and per-channel shifters.
// Build option I2S_TX_ZERO_ON_UNDERRUN_EN: underrun frames send silence instead of repeating the last pair.
module i2s_tx
  import i2s_pkg::*;
#(
  parameter int CLK_DIV_HALF = 32,
  parameter int SAMPLE_W     = 16
) (
  input  logic                       audio_clk,
  input  logic                       rst_in,
  input  logic signed [SAMPLE_W-1:0] sample_l_in,
  input  logic signed [SAMPLE_W-1:0] sample_r_in,
  input  logic                       sample_valid_in,
  output logic                       sample_ready_out,
  output logic                       i2s_bclk,
  output logic                       i2s_lrclk,
  output logic                       i2s_sdata,
  output logic                       frame_start_out,
  output logic                       underrun_out
);

  logic                  fall_evt;
  logic                  load_evt;
  logic [BIT_CNT_W-1:0]  next_bit_cnt;

  logic                  hold_full_q, hold_full_d;
  logic [SAMPLE_W-1:0]   hold_l_q, hold_l_d, hold_r_q, hold_r_d;
  logic [SAMPLE_W-1:0]   shift_l_q, shift_l_d, shift_r_q, shift_r_d;
  logic [SAMPLE_W-1:0]   refill_l, refill_r;
  logic                  sdata_d;
  logic                  accept;
  logic                  data_bit;
  logic [SLOT_IDX_W-1:0] slot_bit;
  i2s_slot_e             slot;

  i2s_clkgen #(
    .CLK_DIV_HALF(CLK_DIV_HALF)
  ) u_clkgen (
    .audio_clk   (audio_clk),
    .rst_in      (rst_in),
    .i2s_bclk    (i2s_bclk),
    .i2s_lrclk   (i2s_lrclk),
    .next_bit_cnt(next_bit_cnt),
    .fall_evt    (fall_evt),
    .load_evt    (load_evt)
  );

  assign sample_ready_out = !hold_full_q;
  assign accept           = sample_valid_in && !hold_full_q;
  assign frame_start_out  = load_evt;
  assign underrun_out     = load_evt && !hold_full_q && !sample_valid_in;

  // Slot bit 0 is the one-BCLK Philips delay; data occupies slot bits 1..SAMPLE_W.
  assign slot     = slot_of(next_bit_cnt);
  assign slot_bit = next_bit_cnt[SLOT_IDX_W-1:0];
  assign data_bit = (slot_bit != '0) && (slot_bit <= SLOT_IDX_W'(SAMPLE_W));

`ifdef I2S_TX_ZERO_ON_UNDERRUN_EN
  assign refill_l = '0;
  assign refill_r = '0;
`else
  logic [SAMPLE_W-1:0] last_l_q, last_r_q;

  // On an underrun the shifters reload from here, so this naturally keeps the last good pair.
  always_ff @(posedge audio_clk or negedge rst_in) begin
    if (!rst_in) begin
      last_l_q <= '0;
      last_r_q <= '0;
    end else if (load_evt) begin
      last_l_q <= shift_l_d;
      last_r_q <= shift_r_d;
    end
  end

  assign refill_l = last_l_q;
  assign refill_r = last_r_q;
`endif

  // A pair offered on an empty-holding load cycle bypasses straight into the shifters.
  always_comb begin
    hold_full_d = hold_full_q;
    hold_l_d    = hold_l_q;
    hold_r_d    = hold_r_q;
    shift_l_d   = shift_l_q;
    shift_r_d   = shift_r_q;
    sdata_d     = i2s_sdata;

    if (load_evt) begin
      hold_full_d = 1'b0;
      if (hold_full_q) begin
        shift_l_d = hold_l_q;
        shift_r_d = hold_r_q;
      end else if (sample_valid_in) begin
        shift_l_d = sample_l_in;
        shift_r_d = sample_r_in;
      end else begin
        shift_l_d = refill_l;
        shift_r_d = refill_r;
      end
    end else if (accept) begin
      hold_full_d = 1'b1;
      hold_l_d    = sample_l_in;
      hold_r_d    = sample_r_in;
    end

    if (fall_evt) begin
      sdata_d = 1'b0;
      if (data_bit) begin
        if (slot == SLOT_L) begin
          sdata_d   = shift_l_q[SAMPLE_W-1];
          shift_l_d = {shift_l_q[SAMPLE_W-2:0], 1'b0};
        end else begin
          sdata_d   = shift_r_q[SAMPLE_W-1];
          shift_r_d = {shift_r_q[SAMPLE_W-2:0], 1'b0};
        end
      end
    end
  end

  always_ff @(posedge audio_clk or negedge rst_in) begin
    if (!rst_in) begin
      hold_full_q <= 1'b0;
      hold_l_q    <= '0;
      hold_r_q    <= '0;
      shift_l_q   <= '0;
      shift_r_q   <= '0;
      i2s_sdata   <= 1'b0;
    end else begin
      hold_full_q <= hold_full_d;
      hold_l_q    <= hold_l_d;
      hold_r_q    <= hold_r_d;
      shift_l_q   <= shift_l_d;
      shift_r_q   <= shift_r_d;
      i2s_sdata   <= sdata_d;
    end
  end

endmodule

// File: tb/tb_i2s_tx.sv
// Randomized self-checking bench for i2s_tx against a cycle-indexed frame model.
module tb_i2s_tx;
  import i2s_pkg::*;

  localparam int CLK_DIV_HALF = 32;
  localparam int SAMPLE_W     = 16;
  localparam int BCLK_CYC     = 2 * CLK_DIV_HALF;
  localparam int FRAME_CYC    = BCLK_CYC * FRAME_BITS;
  localparam logic [5:0] RESET_OUT = 6'b010100;

  typedef enum {M_IDLE, M_PUSH, M_STREAM, M_LOADONLY, M_RANDOM} mode_e;

  logic    audio_clk = 1'b0;
  logic    rst_in;
  sample_t sample_l_in, sample_r_in;
  logic    sample_valid_in;
  logic    sample_ready_out, i2s_bclk, i2s_lrclk, i2s_sdata, frame_start_out, underrun_out;

  int assert_count = 0;
  int fail_count   = 0;
  int n;
  int ur_seen;
  mode_e mode;
  logic    m_hold_full, push_pending;
  sample_t m_hold_l, m_hold_r, m_frame_l, m_frame_r, m_last_l, m_last_r;
  sample_t push_l, push_r, stream_cnt;

  always #5 audio_clk = ~audio_clk;

  i2s_tx #(
    .CLK_DIV_HALF(CLK_DIV_HALF),
    .SAMPLE_W    (SAMPLE_W)
  ) dut (
    .audio_clk       (audio_clk),
    .rst_in          (rst_in),
    .sample_l_in     (sample_l_in),
    .sample_r_in     (sample_r_in),
    .sample_valid_in (sample_valid_in),
    .sample_ready_out(sample_ready_out),
    .i2s_bclk        (i2s_bclk),
    .i2s_lrclk       (i2s_lrclk),
    .i2s_sdata       (i2s_sdata),
    .frame_start_out (frame_start_out),
    .underrun_out    (underrun_out)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    assert_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s t=%0t: got 'h%0h, expected 'h%0h", tag, $time, actual, expected);
    end
  endtask

  function automatic logic [5:0] outputs_vec();
    return {i2s_bclk, i2s_lrclk, i2s_sdata, sample_ready_out, frame_start_out, underrun_out};
  endfunction

  // n = clock edges since reset release; frames load on every 4096th edge starting at edge 64.
  function automatic int bit_idx(input int cyc);
    return (FRAME_BITS - 1 + cyc / BCLK_CYC) % FRAME_BITS;
  endfunction

  function automatic logic is_load_cycle(input int cyc);
    return (cyc >= BCLK_CYC - 1) && ((cyc - (BCLK_CYC - 1)) % FRAME_CYC == 0);
  endfunction

  function automatic logic [5:0] model_outputs(input logic valid);
    int      bc, k;
    logic    sd, load;
    sample_t word;
    bc   = bit_idx(n);
    k    = bc % SLOT_BITS;
    word = (bc >= SLOT_BITS) ? m_frame_r : m_frame_l;
    sd   = (k >= 1 && k <= SAMPLE_W) ? word[SAMPLE_W - k] : 1'b0;
    load = is_load_cycle(n);
    return {1'((n / CLK_DIV_HALF) % 2), 1'(bc >= SLOT_BITS), sd, !m_hold_full,
            load, load && !m_hold_full && !valid};
  endfunction

  task automatic reset_model();
    n = 0;
    m_hold_full = 1'b0;
    push_pending = 1'b0;
    m_hold_l = '0; m_hold_r = '0;
    m_frame_l = '0; m_frame_r = '0;
    m_last_l = '0; m_last_r = '0;
  endtask

  task automatic applyStimulus();
    sample_valid_in = 1'b0;
    sample_l_in = sample_t'($urandom);
    sample_r_in = sample_t'($urandom);
    case (mode)
      M_PUSH: if (push_pending) begin
        sample_valid_in = 1'b1;
        sample_l_in = push_l;
        sample_r_in = push_r;
      end
      M_STREAM: begin
        sample_valid_in = 1'b1;
        sample_l_in = stream_cnt;
        sample_r_in = ~stream_cnt;
      end
      M_LOADONLY: sample_valid_in = is_load_cycle(n) && !m_hold_full;
      M_RANDOM:   sample_valid_in = 1'($urandom_range(0, 1));
      default:    sample_valid_in = 1'b0;
    endcase
  endtask

  // One clock: drive, compare against the model, advance the model across the edge.
  task automatic step();
    logic load, accept;
    applyStimulus();
    #1;
    checkOutput("outputs", 32'(outputs_vec()), 32'(model_outputs(sample_valid_in)));
    if (underrun_out === 1'b1) ur_seen++;
    load   = is_load_cycle(n);
    accept = sample_valid_in && !m_hold_full;
    if (load) begin
      if (m_hold_full) begin
        m_frame_l = m_hold_l; m_frame_r = m_hold_r;
        m_last_l  = m_hold_l; m_last_r  = m_hold_r;
        m_hold_full = 1'b0;
      end else if (sample_valid_in) begin
        m_frame_l = sample_l_in; m_frame_r = sample_r_in;
        m_last_l  = sample_l_in; m_last_r  = sample_r_in;
      end else begin
`ifdef I2S_TX_ZERO_ON_UNDERRUN_EN
        m_frame_l = '0; m_frame_r = '0;
`else
        m_frame_l = m_last_l; m_frame_r = m_last_r;
`endif
      end
    end else if (accept) begin
      m_hold_l = sample_l_in; m_hold_r = sample_r_in;
      m_hold_full = 1'b1;
    end
    if (accept && mode == M_PUSH) push_pending = 1'b0;
    if (accept && mode == M_STREAM) stream_cnt++;
    @(posedge audio_clk);
    n++;
    @(negedge audio_clk);
  endtask

  task automatic run(input mode_e m, input int cycles);
    mode = m;
    repeat (cycles) step();
  endtask

  task automatic push_pair(input sample_t l, input sample_t r);
    push_l = l;
    push_r = r;
    push_pending = 1'b1;
  endtask

  initial begin
    int guard;
    rst_in = 1'b0;
    sample_valid_in = 1'b0;
    sample_l_in = '0;
    sample_r_in = '0;
    stream_cnt = 16'h0100;
    mode = M_IDLE;
    ur_seen = 0;
    reset_model();

    repeat (2) @(negedge audio_clk);
    #1 checkOutput("reset_values", 32'(outputs_vec()), 32'(RESET_OUT));
    @(negedge audio_clk);
    rst_in = 1'b1;

    $display("[TB] idle after reset");
    run(M_IDLE, 4200);
    checkOutput("idle_underruns", ur_seen, 2);

    $display("[TB] single pair 8001/7FFE");
    push_pair(16'h8001, 16'h7FFE);
    run(M_PUSH, FRAME_CYC);
    run(M_IDLE, FRAME_CYC);

    $display("[TB] continuous stream");
    ur_seen = 0;
    run(M_STREAM, 3 * FRAME_CYC);
    checkOutput("stream_underruns", ur_seen, 0);

    $display("[TB] load-cycle bypass");
    ur_seen = 0;
    run(M_LOADONLY, 2 * FRAME_CYC);
    checkOutput("bypass_underruns", ur_seen, 0);

    $display("[TB] pair then starve");
    push_pair(16'h1234, 16'h5678);
    run(M_PUSH, FRAME_CYC);
    run(M_IDLE, 2 * FRAME_CYC);

    $display("[TB] random traffic");
    run(M_RANDOM, 2 * FRAME_CYC);

    $display("[TB] reset mid-frame");
    mode = M_IDLE;
    guard = 0;
    while (bit_idx(n) != 2 && guard < 2 * FRAME_CYC) begin step(); guard++; end
    push_pair(sample_t'($urandom), sample_t'($urandom));
    mode = M_PUSH;
    guard = 0;
    while (push_pending && guard < 2 * FRAME_CYC) begin step(); guard++; end
    mode = M_IDLE;
    guard = 0;
    while (bit_idx(n) != 40 && guard < 2 * FRAME_CYC) begin step(); guard++; end
    checkOutput("ready_before_reset", 32'(sample_ready_out), 32'(1'b0));
    #2 rst_in = 1'b0;
    #1 checkOutput("reset_async", 32'(outputs_vec()), 32'(RESET_OUT));
    repeat (3) begin
      @(negedge audio_clk);
      #1 checkOutput("reset_hold", 32'(outputs_vec()), 32'(RESET_OUT));
    end
    @(negedge audio_clk);
    rst_in = 1'b1;
    reset_model();
    ur_seen = 0;
    run(M_IDLE, 2 * FRAME_CYC);
    checkOutput("post_reset_underruns", ur_seen, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
